mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 one-bit mux path between 8 requesters.
- Each requester holds its line until it raises done.
- Drives the registered 3-bit select for the downstream 8:1 mux, plus a one-hot grant and a busy flag back to the requesters.
- Sits between the requester bank and the mux; it is the only source of the mux select.

---
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requester bank and the 8:1 mux arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until granted; ownership ends on done or req drop.
interface mux_rr_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int SEL_W = 3
);
  logic [N_REQ-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             timeout;

  // Requester bank side
  modport master (
    output req, done,
    input  sel, grant, busy, timeout
  );

  // Arbiter side
  modport slave (
    input  req, done,
    output sel, grant, busy, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 8:1 one-bit mux; drives registered select/grant/busy.
// Latency: 1 cycle req->grant; 1 cycle release->idle; one idle bubble between owners.
// Backpressure: requests seen in GRANT wait for IDLE; no preemption.
// Optional forced release after HOLD_MAX cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             timeout_q;
  logic [SEL_W-1:0] ptr_q;
  logic [7:0]       hold_cnt_q;

  logic [SEL_W-1:0] sel_d;
  logic             any_req;
  logic             release_c;
  logic             force_rel;

  // Rotating priority search: walk from the far end back to ptr so the
  // last hit is the first set bit in search order starting at ptr.
  always_comb begin
    sel_d   = ptr_q;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[ptr_q + SEL_W'(i)]) begin
        sel_d   = ptr_q + SEL_W'(i);
        any_req = 1'b1;
      end
    end
  end

  // Owner gives up the mux on done or by dropping its request; the hold
  // limit only forces a release when the owner is not already leaving.
  always_comb begin
    release_c = bus.done | ~bus.req[sel_q];
    force_rel = TO_EN & (hold_cnt_q == 8'(HOLD_MAX - 1)) & ~release_c;
  end

  // Arbiter FSM with all outputs registered; sel only moves on a new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= GRANT;
            sel_q      <= sel_d;
            grant_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (release_c | force_rel) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= sel_q + 1'b1;
            timeout_q <= force_rel;
          end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: scoreboard of predicted outputs
// plus directed checks of the round-robin order, release, reset and hold limit.
module tb_mux_rr_arbiter;
  localparam int HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TB_TO = 1'b1;
`else
  localparam bit TB_TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.N_REQ(8), .SEL_W(3), .HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_to  = 0;

  // Reference state: owner index, search start, hold counter
  int m_busy, m_sel, m_ptr, m_hold;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0;
    m_sel  = 0;
    m_ptr  = 0;
    m_hold = 0;
  endfunction

  // Drive one cycle of inputs, predict the outputs after the next edge,
  // then compare the DUT against the queued prediction.
  task automatic step(input logic [7:0] r, input logic d);
    exp_t e;
    bit   found;
    bit   rel;
    bit   to;
    int   k;
    bus.req  = r;
    bus.done = d;
    found = 1'b0;
    to    = 1'b0;
    if (m_busy == 0) begin
      for (int i = 0; i < 8; i++) begin
        k = (m_ptr + i) % 8;
        if (!found && r[k]) begin
          found = 1'b1;
          m_sel = k;
        end
      end
      if (found) begin
        m_busy = 1;
        m_hold = 0;
      end
    end else begin
      rel = d || !r[m_sel];
      if (!rel && TB_TO && m_hold == HOLD - 1) begin
        rel = 1'b1;
        to  = 1'b1;
      end
      if (rel) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 8;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
    e.sel   = m_sel[2:0];
    e.grant = (m_busy != 0) ? (8'h01 << m_sel) : 8'h00;
    e.busy  = (m_busy != 0);
    e.to    = to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sel",     32'(bus.sel),     32'(e.sel));
    chk("grant",   32'(bus.grant),   32'(e.grant));
    chk("busy",    32'(bus.busy),    32'(e.busy));
    chk("timeout", 32'(bus.timeout), 32'(e.to));
    if (bus.timeout === 1'b1) n_to++;
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst      = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel",   32'(bus.sel),     32'd0);
    chk("rst_grant", 32'(bus.grant),   32'd0);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_to",    32'(bus.timeout), 32'd0);
    rst = 1'b0;

    // Quiet bus
    repeat (10) step(8'h00, 1'b0);

    // Everyone requesting, owner leaves with done: 0,1,..,7,0
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      chk("rr_sel",   32'(bus.sel),   32'(i % 8));
      chk("rr_grant", 32'(bus.grant), 32'h1 << (i % 8));
      step(8'hFF, 1'b1);
      chk("rr_bubble", 32'(bus.busy), 32'd0);
    end

    // Lone requester 5, released by done; search then resumes at 6
    step(8'h20, 1'b0);
    chk("r5_grant", 32'(bus.grant), 32'h20);
    chk("r5_sel",   32'(bus.sel),   32'd5);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    chk("r5_release", 32'(bus.grant), 32'h00);
    step(8'h21, 1'b0);
    chk("after5_sel", 32'(bus.sel), 32'd0);
    step(8'h00, 1'b0);

    // Owner 2 drops its request without done; next search starts at 3
    step(8'h04, 1'b0);
    chk("r2_sel", 32'(bus.sel), 32'd2);
    step(8'h04, 1'b0);
    step(8'h02, 1'b0);
    chk("r2_drop_busy", 32'(bus.busy), 32'd0);
    step(8'h06, 1'b0);
    chk("wrap_sel", 32'(bus.sel), 32'd1);
    step(8'h00, 1'b0);

    // Asynchronous reset while requester 4 owns the mux
    step(8'h10, 1'b0);
    chk("r4_grant", 32'(bus.grant), 32'h10);
    step(8'h10, 1'b0);
    rst = 1'b1;
    #2;
    chk("arst_grant", 32'(bus.grant),   32'd0);
    chk("arst_busy",  32'(bus.busy),    32'd0);
    chk("arst_sel",   32'(bus.sel),     32'd0);
    chk("arst_to",    32'(bus.timeout), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'h10, 1'b0);
    chk("post_rst_grant", 32'(bus.grant), 32'h10);
    chk("post_rst_sel",   32'(bus.sel),   32'd4);
    step(8'h00, 1'b0);

    // Owner 0 never lets go
    n_to = 0;
    repeat (100) step(8'h01, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
    chk("to_pulses", 32'(n_to), 32'd20);
`else
    chk("hold_grant", 32'(bus.grant), 32'h01);
    chk("no_to",      32'(n_to),      32'd0);
`endif
    step(8'h00, 1'b0);

    // Random traffic, done asserted about a quarter of the time
    repeat (400) step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
